// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: MEM-stage data-memory controller for a 5-stage RV32I pipeline.
// Turns a MEM-stage load/store into one valid/ready bus request, waits for the
// load response and returns the sign/zero-extended result for writeback.
// Optional watchdog: define DMEM_TIMEOUT_EN to abort REQ/WAIT after TIMEOUT_CYCLES.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   mem_read_MEM          load present in MEM
//   mem_write_MEM         store present in MEM
//   funct3_MEM            RV32I width/sign code
//   addr_MEM, wdata_MEM   byte address, right-aligned store data
//   rdata_MEM             extended load result (registered)
//   data_mem_hazard       stall request to hazard unit (combinational)
//   misaligned_MEM        misaligned-access flag (combinational)
//   bus_error_MEM         watchdog abort, one cycle (registered, 0 without watchdog)
//   bus_req_*             request channel (registered)
//   bus_resp_valid/data   read response channel
module dmem_access_ctrl #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read_MEM,
  input  logic                  mem_write_MEM,
  input  logic [2:0]            funct3_MEM,
  input  logic [ADDR_WIDTH-1:0] addr_MEM,
  input  logic [31:0]           wdata_MEM,
  output logic [31:0]           rdata_MEM,
  output logic                  data_mem_hazard,
  output logic                  misaligned_MEM,
  output logic                  bus_error_MEM,
  output logic                  bus_req_valid,
  input  logic                  bus_req_ready,
  output logic                  bus_req_we,
  output logic [ADDR_WIDTH-1:0] bus_req_addr,
  output logic [31:0]           bus_req_wdata,
  output logic [3:0]            bus_req_be,
  input  logic                  bus_resp_valid,
  input  logic [31:0]           bus_resp_data
);

  // Only a 32-bit datapath exists; the watchdog needs at least a 1-bit counter.
  if (DATA_WIDTH != 32 || TIMEOUT_CYCLES < 2) begin : g_bad_param
    $error("dmem_access_ctrl: DATA_WIDTH must be 32 and TIMEOUT_CYCLES >= 2");
  end

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t                state_q, state_d;
  logic                  valid_d, we_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [31:0]           wdata_d, rdata_d;
  logic [3:0]            be_d;
  logic [1:0]            ld_width_q, ld_width_d, ld_off_q, ld_off_d;
  logic                  ld_unsigned_q, ld_unsigned_d;
  logic                  req_present, timeout_abort;
  logic [1:0]            width, off;
  logic [3:0]            st_be;
  logic [31:0]           st_wdata, ld_ext;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;

  // Request decode; funct3[1:0]=11 falls into the word case.
  always_comb begin
    req_present     = mem_read_MEM | mem_write_MEM;
    width           = funct3_MEM[1:0];
    off             = addr_MEM[1:0];
    misaligned_MEM  = req_present &&
                      ((width == 2'b01 && off[0]) || (width[1] && off != 2'b00));
    data_mem_hazard = (state_q == IDLE && req_present && !misaligned_MEM) ||
                      state_q == REQ || state_q == WAIT;
  end

  // Store lane steering: replicate the datum, enable only the addressed lanes.
  always_comb begin
    case (width)
      2'b00: begin
        st_be    = 4'b0001 << off;
        st_wdata = {4{wdata_MEM[7:0]}};
      end
      2'b01: begin
        st_be    = 4'b0011 << off;
        st_wdata = {2{wdata_MEM[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = wdata_MEM;
      end
    endcase
  end

  // Load extraction from the latched lane/width/sign info.
  always_comb begin
    ld_byte = bus_resp_data[{ld_off_q, 3'b000} +: 8];
    ld_half = ld_off_q[1] ? bus_resp_data[31:16] : bus_resp_data[15:0];
    case (ld_width_q)
      2'b00:   ld_ext = ld_unsigned_q ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'b01:   ld_ext = ld_unsigned_q ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ld_ext = bus_resp_data;
    endcase
  end

  // Next-state and next-register values.
  always_comb begin
    state_d       = state_q;
    valid_d       = bus_req_valid;
    we_d          = bus_req_we;
    addr_d        = bus_req_addr;
    wdata_d       = bus_req_wdata;
    be_d          = bus_req_be;
    rdata_d       = rdata_MEM;
    ld_width_d    = ld_width_q;
    ld_off_d      = ld_off_q;
    ld_unsigned_d = ld_unsigned_q;
    case (state_q)
      IDLE: begin
        if (req_present) begin
          if (misaligned_MEM) begin
            rdata_d = 32'h0;
          end else begin
            state_d       = REQ;
            valid_d       = 1'b1;
            we_d          = mem_write_MEM;
            addr_d        = {addr_MEM[ADDR_WIDTH-1:2], 2'b00};
            be_d          = mem_write_MEM ? st_be : 4'b0000;
            wdata_d       = mem_write_MEM ? st_wdata : 32'h0;
            ld_width_d    = width;
            ld_off_d      = off;
            ld_unsigned_d = funct3_MEM[2];
          end
        end
      end
      REQ: begin
        if (bus_req_ready) begin
          valid_d = 1'b0;
          state_d = bus_req_we ? DONE : WAIT;
        end else if (timeout_abort) begin
          valid_d = 1'b0;
          rdata_d = 32'h0;
          state_d = DONE;
        end
      end
      WAIT: begin
        if (bus_resp_valid) begin
          rdata_d = ld_ext;
          state_d = DONE;
        end else if (timeout_abort) begin
          rdata_d = 32'h0;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      bus_req_valid <= 1'b0;
      bus_req_we    <= 1'b0;
      bus_req_addr  <= '0;
      bus_req_wdata <= 32'h0;
      bus_req_be    <= 4'h0;
      rdata_MEM     <= 32'h0;
      ld_width_q    <= 2'b00;
      ld_off_q      <= 2'b00;
      ld_unsigned_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      bus_req_valid <= valid_d;
      bus_req_we    <= we_d;
      bus_req_addr  <= addr_d;
      bus_req_wdata <= wdata_d;
      bus_req_be    <= be_d;
      rdata_MEM     <= rdata_d;
      ld_width_q    <= ld_width_d;
      ld_off_q      <= ld_off_d;
      ld_unsigned_q <= ld_unsigned_d;
    end
  end

`ifdef DMEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] tmo_cnt_q;
  logic             tmo_hit;

  // Counter restarts on every state change, so it measures time in the current REQ/WAIT.
  assign tmo_hit       = (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign timeout_abort = tmo_hit &&
                         ((state_q == REQ && !bus_req_ready) ||
                          (state_q == WAIT && !bus_resp_valid));

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q     <= '0;
      bus_error_MEM <= 1'b0;
    end else begin
      bus_error_MEM <= timeout_abort;
      if (state_d != state_q) begin
        tmo_cnt_q <= '0;
      end else if (state_q == REQ || state_q == WAIT) begin
        tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
      end
    end
  end
`else
  assign timeout_abort = 1'b0;
  assign bus_error_MEM = 1'b0;
`endif

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- MEM-stage data-memory controller for the 5-stage RISC-V pipeline.
- Converts the MEM-stage load/store into a valid/ready request on the data bus, then waits for load responses.
- Drives data_mem_hazard to the hazard detection unit for the whole access and returns extended load data to writeback.
- The MEM stage holds while data_mem_hazard=1 and advances in the first cycle it is 0.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, bus/register width; only 32 is supported.
- TIMEOUT_CYCLES, 64, watchdog limit. Used only with DMEM_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_read_MEM  in  1  load in MEM stage.
- mem_write_MEM  in  1  store in MEM stage (mutually exclusive with mem_read_MEM).
- funct3_MEM  in  3  RV32I width/sign code: LB=000, LH=001, LW=010, LBU=100, LHU=101, SB=000, SH=001, SW=010.
- addr_MEM  in  ADDR_WIDTH  byte address.
- wdata_MEM  in  32  store data, right-aligned.
- rdata_MEM  out  32  extended load result, registered.
- data_mem_hazard  out  1  combinational stall request to the hazard detection unit.
- misaligned_MEM  out  1  combinational misaligned-access flag.
- bus_error_MEM  out  1  access aborted by watchdog. Constant 0 without DMEM_TIMEOUT_EN.
- bus_req_valid  out  1  request valid, registered.
- bus_req_ready  in  1  slave accepts the request.
- bus_req_we  out  1  1 = write.
- bus_req_addr  out  ADDR_WIDTH  word-aligned address, addr[1:0]=00.
- bus_req_wdata  out  32  lane-shifted store data.
- bus_req_be  out  4  byte enables (0000 for reads).
- bus_resp_valid  in  1  read data valid.
- bus_resp_data  in  32  read word.

Behaviour:
- Reset values:
  - state=IDLE.
  - bus_req_valid=0, bus_req_we=0, bus_req_addr=0, bus_req_wdata=0, bus_req_be=0.
  - rdata_MEM=0, bus_error_MEM=0.
- Misaligned access:
  - Condition: LW/SW with addr[1:0]!=0, or LH/LHU/SH with addr[0]=1.
  - misaligned_MEM=1, no bus request, data_mem_hazard=0, rdata_MEM=0 the next cycle.
- data_mem_hazard:
  - Equals 1 when (state==IDLE and aligned request present) or state in {REQ, WAIT}.
  - Equals 0 in DONE and when idle with no request.
- FSM states: IDLE, REQ, WAIT, DONE.
  - IDLE -> REQ on an aligned request. In that edge, latch bus_req_addr/we/be/wdata and the sign/width info, and set bus_req_valid=1.
  - REQ: hold all bus_req_* stable until bus_req_valid & bus_req_ready. On the handshake, bus_req_valid drops the next cycle.
    - Store: go to DONE.
    - Load: go to WAIT.
  - WAIT: on bus_resp_valid, capture the extended data into rdata_MEM and go to DONE.
  - DONE: go to IDLE unconditionally. rdata_MEM holds for writeback.
- Latency:
  - Store: 2 stall cycles when ready is high immediately.
  - Load: 3 stall cycles minimum (ready and resp each one cycle later).
  - Each extra cycle of ready or resp delay adds one stall cycle.
- Store lane shifting (off = addr[1:0]):
  - SB: be=0001<<off, wdata = {4{byte}}.
  - SH: be=0011<<off (off in {0,2}), wdata = {2{half}}.
  - SW: be=1111, wdata unchanged.
- Load extraction: select byte/half by off from bus_resp_data.
  - LB/LH: sign-extend.
  - LBU/LHU: zero-extend.
  - LW: whole word.
- bus_resp_valid outside WAIT is ignored.
- Unsupported funct3 values (011, 110, 111) are treated as LW/SW width.
- Reset mid-operation: return to IDLE and drop bus_req_valid in the same edge. A response arriving after reset is ignored.

Optional Feature:
- Macro: DMEM_TIMEOUT_EN.
- With the macro:
  - A counter clears on entry to REQ or WAIT and increments each cycle spent in REQ or WAIT.
  - When the counter reaches TIMEOUT_CYCLES-1 without the awaited handshake/response, go to DONE and drop bus_req_valid.
  - Set bus_error_MEM=1 for the DONE cycle only, with rdata_MEM=0.
- Without the macro: no counter is present, REQ/WAIT wait indefinitely, and bus_error_MEM is tied to 0.

Test Plan:
- SW addr=0x100, wdata=0xDEADBEEF, ready high -> req addr 0x100, be=1111, hazard high 2 cycles, then low; no resp needed.
- SB addr=0x203, wdata=0x000000A5, ready delayed 3 cycles -> be=1000, wdata=0xA5A5A5A5, request fields stable throughout, hazard high 5 cycles.
- LB addr=0x301, resp_data=0x00008000 one cycle after accept -> rdata_MEM=0xFFFFFF80. Same access as LBU -> 0x00000080. LHU addr=0x302, resp=0xBEEF0000 -> 0x0000BEEF.
- LW addr=0x102 -> misaligned_MEM=1, no bus_req_valid, hazard 0, rdata_MEM=0.
- Load in WAIT, rst pulsed 1 cycle, late resp_valid -> state IDLE, bus_req_valid 0, rdata_MEM stays 0, hazard 0.
- DMEM_TIMEOUT_EN, TIMEOUT_CYCLES=8, ready stuck low -> bus_req_valid drops after 8 REQ cycles; bus_error_MEM=1 one cycle; hazard low that cycle.
